// File: rtl/exu_issue_queue_if.sv
// Handshake bundle between decode, the issue queue and exu.
// The slave modport is the queue's side; the master modport is the decode/exu side.
interface exu_issue_queue_if #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PAYLOAD_W = 256
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic                 enq_valid;
    logic                 enq_ready;
    logic [PAYLOAD_W-1:0] enq_payload;
    logic                 issue_valid;
    logic                 issue_ready;
    logic [PAYLOAD_W-1:0] issue_payload;
    logic [CNT_W-1:0]     count;
    logic                 full;
    logic                 empty;

    modport master (
        output enq_valid, enq_payload, issue_ready,
        input  enq_ready, issue_valid, issue_payload, count, full, empty
    );

    modport slave (
        input  enq_valid, enq_payload, issue_ready,
        output enq_ready, issue_valid, issue_payload, count, full, empty
    );
endinterface

// File: rtl/exu_issue_queue.sv
// In-order issue buffer between decode and exu. Holds up to DEPTH opaque uops.
// A flush from the redirect path empties the queue on the next cycle.
module exu_issue_queue #(
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned PAYLOAD_W = 256
) (
    input logic              clock,
    input logic              reset,
    input logic              flush,
    exu_issue_queue_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = IDX_W + 1;

    logic [PAYLOAD_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0]     wr_idx, rd_idx;
    logic                 full, empty;
    logic                 enq_fire, deq_fire;

    assign wr_idx = wr_ptr_q[IDX_W-1:0];
    assign rd_idx = rd_ptr_q[IDX_W-1:0];

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign full  = (wr_idx == rd_idx) && (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);
    assign empty = (wr_ptr_q == rd_ptr_q);

    assign enq_fire = bus.enq_valid && bus.enq_ready;
    assign deq_fire = bus.issue_valid && bus.issue_ready && !flush;

    assign bus.enq_ready     = !full && !flush;
    assign bus.issue_valid   = !empty;
    assign bus.issue_payload = mem_q[rd_idx];
    assign bus.count         = wr_ptr_q - rd_ptr_q;
    assign bus.full          = full;
    assign bus.empty         = empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (enq_fire) wr_ptr_d = wr_ptr_q + 1'b1;
            if (deq_fire) rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage is intentionally not reset; pointers alone define validity.
    always_ff @(posedge clock) begin
        if (enq_fire && !reset) begin
            mem_q[wr_idx] <= bus.enq_payload;
        end
    end
endmodule

// File: tb/tb_exu_issue_queue.sv
// Self-checking bench for exu_issue_queue: directed scenarios plus random traffic,
// all compared every cycle against a payload-queue reference model.
module tb_exu_issue_queue;
    localparam int unsigned DEPTH     = 4;
    localparam int unsigned PAYLOAD_W = 256;

    logic clock = 1'b0;
    logic reset;
    logic flush;

    exu_issue_queue_if #(.DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W)) bus ();

    exu_issue_queue #(.DEPTH(DEPTH), .PAYLOAD_W(PAYLOAD_W)) dut (
        .clock (clock),
        .reset (reset),
        .flush (flush),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;
    bit known    = 1'b0;

    logic [PAYLOAD_W-1:0] mq     [$];
    logic [PAYLOAD_W-1:0] got_q  [$];

    task automatic check(input string tag, input logic [PAYLOAD_W-1:0] got,
                         input logic [PAYLOAD_W-1:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, check outputs against the model, advance the model.
    task automatic cycle(input logic r, input logic f, input logic ev,
                         input logic [PAYLOAD_W-1:0] ep, input logic ir);
        int sz;
        bit do_enq, do_deq;
        reset             = r;
        flush             = f;
        bus.enq_valid     = ev;
        bus.enq_payload   = ep;
        bus.issue_ready   = ir;
        #1;
        sz = mq.size();
        if (known) begin
            check("count", PAYLOAD_W'(bus.count), PAYLOAD_W'(sz));
            check("full", PAYLOAD_W'(bus.full), PAYLOAD_W'(sz == DEPTH));
            check("empty", PAYLOAD_W'(bus.empty), PAYLOAD_W'(sz == 0));
            check("issue_valid", PAYLOAD_W'(bus.issue_valid), PAYLOAD_W'(sz != 0));
            check("enq_ready", PAYLOAD_W'(bus.enq_ready), PAYLOAD_W'((sz != DEPTH) && !f));
            if (sz != 0) check("issue_payload", bus.issue_payload, mq[0]);
        end
        do_deq = !r && !f && (sz != 0) && ir;
        do_enq = !r && !f && ev && (sz < DEPTH);
        if (do_deq) got_q.push_back(bus.issue_payload);
        @(posedge clock);
        #1;
        if (r || f) begin
            mq.delete();
            if (r) known = 1'b1;
        end else begin
            if (do_deq) void'(mq.pop_front());
            if (do_enq) mq.push_back(ep);
        end
    endtask

    function automatic logic [PAYLOAD_W-1:0] rand_payload();
        logic [PAYLOAD_W-1:0] p;
        for (int i = 0; i < PAYLOAD_W / 32; i++) p[i*32 +: 32] = $urandom;
        return p;
    endfunction

    initial begin
        logic [PAYLOAD_W-1:0] exp2 [5];
        exp2[0] = 'h11; exp2[1] = 'h22; exp2[2] = 'h33; exp2[3] = 'h44; exp2[4] = 'h55;

        // 1: reset held with enq_valid asserted, then first uop appears a cycle later
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 'hDEAD, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 'hA1, 1'b0);
        check("first_enq_visible", PAYLOAD_W'(bus.issue_valid), PAYLOAD_W'(1));
        check("first_enq_payload", bus.issue_payload, 'hA1);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);

        // 2 + 4: fill, hold fifth while full, drain (includes full+deq same cycle)
        got_q.delete();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, exp2[i], 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 'h55, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 'h55, 1'b1);
        check("count_after_full_deq", PAYLOAD_W'(bus.count), PAYLOAD_W'(3));
        check("enq_ready_reopens", PAYLOAD_W'(bus.enq_ready), PAYLOAD_W'(1));
        cycle(1'b0, 1'b0, 1'b1, 'h55, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        check("fill_drain_len", PAYLOAD_W'(got_q.size()), PAYLOAD_W'(5));
        for (int i = 0; i < 5 && i < got_q.size(); i++) check("fill_drain_order", got_q[i], exp2[i]);

        // 3: streaming with simultaneous enq/deq, pointers wrap several times
        got_q.delete();
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b1, PAYLOAD_W'(i), 1'b1);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        check("stream_len", PAYLOAD_W'(got_q.size()), PAYLOAD_W'(20));
        for (int i = 0; i < 20 && i < got_q.size(); i++) check("stream_order", got_q[i], PAYLOAD_W'(i));

        // 5: flush with both handshakes offered drops everything
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, PAYLOAD_W'(8'hC0 + i), 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 'hBB, 1'b1);
        check("flush_empty", PAYLOAD_W'(bus.empty), PAYLOAD_W'(1));
        check("flush_count", PAYLOAD_W'(bus.count), PAYLOAD_W'(0));
        got_q.delete();
        cycle(1'b0, 1'b0, 1'b1, 'hAA, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b1);
        check("post_flush_first", (got_q.size() > 0) ? got_q[0] : '1, 'hAA);

        // 6: random traffic against the model
        for (int i = 0; i < 10000; i++) begin
            cycle(($urandom_range(0, 499) == 0), ($urandom_range(0, 31) == 0),
                  1'($urandom_range(0, 1)), rand_payload(), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
